// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding,
// the divide-by-zero quotient pattern and the step-counter sizing helper.
package div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Sliced down to the operand width by the divider (operands up to 64 bits).
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int step_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left by one, pull in
// the next dividend bit and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_trial_msb;

  // The shifted remainder can exceed 2^WIDTH, so compare and subtract at WIDTH+1 bits;
  // a successful trial is always below the divisor, so its top bit is zero.
  always_comb begin
    shifted = {r_in, q_msb_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    r_out   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  assign unused_trial_msb = trial[WIDTH];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, signed or unsigned per request.
// Define DIV_SEQ_EARLY_OUT_EN to skip the dividend's leading zeros and shorten the run.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dvdnd,
  input  logic [WIDTH-1:0] dvsor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rmdr,
  output logic             dz,
  output logic             busy,
  output logic             valid
);

  localparam int CW = step_cnt_w(WIDTH);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_mag;
  logic             q_neg;
  logic             r_neg;
  logic             dz_pend;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag_in;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  // The most-negative value negates to itself, which read unsigned is the correct magnitude.
  always_comb begin
    a_neg    = sgn & dvdnd[WIDTH-1];
    b_neg    = sgn & dvsor[WIDTH-1];
    a_mag    = a_neg ? -dvdnd : dvdnd;
    b_mag_in = b_neg ? -dvsor : dvsor;
  end

`ifdef DIV_SEQ_EARLY_OUT_EN
  logic [CW-1:0] lz;

  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (a_mag[i]) lz = CW'(WIDTH - 1 - i);
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in     (r_reg),
    .q_msb_in (q_reg[WIDTH-1]),
    .divisor  (b_mag),
    .r_out    (r_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      r_reg   <= '0;
      q_reg   <= '0;
      b_mag   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz_pend <= 1'b0;
      quot    <= '0;
      rmdr    <= '0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= start;
          if (start) begin
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            b_mag <= b_mag_in;
            r_reg <= '0;
            // On divide-by-zero the raw dividend parks in q_reg to become the remainder.
            if (dvsor == '0) begin
              dz_pend <= 1'b1;
              q_reg   <= dvdnd;
              cnt     <= '0;
              state   <= ST_FIX;
            end else begin
              dz_pend <= 1'b0;
`ifdef DIV_SEQ_EARLY_OUT_EN
              if (a_mag == '0) begin
                q_reg <= '0;
                cnt   <= '0;
                state <= ST_FIX;
              end else begin
                q_reg <= a_mag << lz;
                cnt   <= CW'(WIDTH) - lz;
                state <= ST_RUN;
              end
`else
              q_reg <= a_mag;
              cnt   <= CW'(WIDTH);
              state <= ST_RUN;
`endif
            end
          end
        end
        ST_RUN: begin
          r_reg <= r_next;
          q_reg <= {q_reg[WIDTH-2:0], q_bit};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (dz_pend) begin
            quot <= DIV_ZERO_QUOT[WIDTH-1:0];
            rmdr <= q_reg;
          end else begin
            quot <= q_neg ? -q_reg : q_reg;
            rmdr <= r_neg ? -r_reg : r_reg;
          end
          dz    <= dz_pend;
          state <= ST_DONE;
        end
        ST_DONE: begin
          valid <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed corner cases plus random operands checked
// against a 64-bit arithmetic reference model, including result latency.
module tb_div_seq;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] dvdnd;
  logic [WIDTH-1:0] dvsor;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rmdr;
  logic             dz;
  logic             busy;
  logic             valid;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int unsigned      cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        monExp;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic        prevValid = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  div_seq #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .sgn   (sgn),
    .dvdnd (dvdnd),
    .dvsor (dvsor),
    .quot  (quot),
    .rmdr  (rmdr),
    .dz    (dz),
    .busy  (busy),
    .valid (valid)
  );

  // Reference: plain 64-bit division, which truncates toward zero for signed operands.
  function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s);
    exp_t   e;
    longint sa, sbv, qq, rr;
    e.cyc = 0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      if (s) begin
        sa  = longint'(signed'(a));
        sbv = longint'(signed'(b));
      end else begin
        sa  = longint'(a);
        sbv = longint'(b);
      end
      qq   = sa / sbv;
      rr   = sa % sbv;
      e.q  = qq[WIDTH-1:0];
      e.r  = rr[WIDTH-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Edges from the start-accepting edge to the edge after which valid is visible.
  function automatic int refLatency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s);
    longint mag;
    int     bits;
    if (b == '0) return 2;
`ifdef DIV_SEQ_EARLY_OUT_EN
    mag = (s && a[WIDTH-1]) ? (longint'(1) << WIDTH) - longint'(a) : longint'(a);
    if (mag == 0) return 2;
    bits = 0;
    while (mag > 0) begin
      bits++;
      mag = mag / 2;
    end
    return bits + 2;
`else
    mag  = 0;
    bits = WIDTH;
    return bits + 2 + int'(mag);
`endif
  endfunction

  task automatic reportFail(input string name, input logic [63:0] act, input logic [63:0] exp);
    errors++;
    $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) reportFail(name, act, exp);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (valid === 1'b1) begin
      if (prevValid) reportFail("valid_width", 64'd2, 64'd1);
      if (sb.size() == 0) begin
        reportFail("unexpected_valid", 64'd1, 64'd0);
      end else begin
        monExp = sb.pop_front();
        checkOutput("quot", 64'(quot), 64'(monExp.q));
        checkOutput("rmdr", 64'(rmdr), 64'(monExp.r));
        checkOutput("dz", 64'(dz), 64'(monExp.dz));
        checkOutput("latency", 64'(cyc), 64'(monExp.cyc));
      end
    end
    prevValid = (valid === 1'b1);
  end

  // Called at a negedge; returns the cycle stamp just after the accepting edge.
  task automatic startOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         output int unsigned c0);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy) reportFail("busy_timeout", 64'(busy), 64'd0);
    dvdnd = a;
    dvsor = b;
    sgn   = s;
    start = 1'b1;
    @(posedge clock);
    #1;
    c0 = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s);
    int unsigned c0;
    exp_t        e;
    startOp(a, b, s, c0);
    e     = refModel(a, b, s);
    e.cyc = c0 + 32'(refLatency(a, b, s));
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) reportFail("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int unsigned      c0;
    logic [WIDTH-1:0] a, b;
    logic             s;

    reset = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    dvdnd = '0;
    dvsor = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset_quot", 64'(quot), 64'd0);
    checkOutput("reset_rmdr", 64'(rmdr), 64'd0);
    checkOutput("reset_dz", 64'(dz), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_valid", 64'(valid), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(32'd100, 32'd7, 1'b1);
    applyStimulus(-32'sd100, 32'd7, 1'b1);
    applyStimulus(32'd100, -32'sd7, 1'b1);
    applyStimulus(-32'sd100, -32'sd7, 1'b1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0);
    applyStimulus(32'h1234, 32'd0, 1'b1);
    applyStimulus(32'h1234, 32'd0, 1'b0);
    applyStimulus(32'd5, 32'd3, 1'b0);
    applyStimulus(32'd0, 32'd9, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(32'h8000_0000, 32'd1, 1'b0);

    // A second start while running must be ignored.
    applyStimulus(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clock);
    checkOutput("busy_in_run", 64'(busy), 64'd1);
    dvdnd = 32'd77;
    dvsor = 32'd5;
    sgn   = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain();

    // Reset in the middle of a run aborts it with no result.
    startOp(32'd12345, 32'd7, 1'b0, c0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_quot", 64'(quot), 64'd0);
    checkOutput("abort_rmdr", 64'(rmdr), 64'd0);
    checkOutput("abort_dz", 64'(dz), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_valid", 64'(valid), 64'd0);
    reset = 1'b0;
    repeat (WIDTH + 6) @(negedge clock);
    checkOutput("abort_idle", 64'(busy), 64'd0);
    applyStimulus(32'd12345, 32'd7, 1'b0);

    for (int i = 0; i < 600; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: a = '0;
        3: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        4: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      applyStimulus(a, b, s);
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
